// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the pipelined add/subtract datapath.
package adder_pkg;

    // Sign bits of the stage-0 operands; they travel with the beat for the overflow check.
    typedef struct packed {
        logic a_msb;
        logic b_msb;
    } beat_t;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit legal_config(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// One pipeline stage: resolves chunk IDX of the sum, keeping the resolved lower
// chunks and the still-unresolved upper operand chunks in the same word.
module adder_slice
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CW    = 4,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             vld,
    input  logic             carry,
    input  logic [WIDTH-1:0] word,
    input  logic [WIDTH-1:0] opb,
    input  beat_t            side,
    output logic             vld_p,
    output logic             carry_p,
    output logic [WIDTH-1:0] word_p,
    output logic [WIDTH-1:0] opb_p,
    output beat_t            side_p
);

    logic [CW:0]      chunk_sum;
    logic [WIDTH-1:0] word_next;

    assign chunk_sum = {1'b0, word[IDX*CW +: CW]} + {1'b0, opb[IDX*CW +: CW]}
                     + {{CW{1'b0}}, carry};

    always_comb begin
        word_next               = word;
        word_next[IDX*CW +: CW] = chunk_sum[CW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= 1'b0;
        end else if (load) begin
            vld_p <= vld;
        end
    end

    // Datapath registers carry no reset; the valid bit qualifies them.
    always_ff @(posedge clk) begin
        if (load) begin
            carry_p <= chunk_sum[CW];
            word_p  <= word_next;
            opb_p   <= opb;
            side_p  <= side;
        end
    end

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract with the carry chain split over STAGES registered chunks
// and valid/ready handshakes on both sides; bubbles collapse under backpressure.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = chunk_width(WIDTH, STAGES);

    if (!legal_config(WIDTH, STAGES)) begin : g_cfg_check
        $error("pipelined_adder: STAGES must lie in 1..WIDTH and divide WIDTH");
    end

    // Index k is the input of stage k; index STAGES is the final stage output.
    logic             vld_bus   [STAGES+1];
    logic             carry_bus [STAGES+1];
    logic [WIDTH-1:0] word_bus  [STAGES+1];
    logic [WIDTH-1:0] opb_bus   [STAGES+1];
    beat_t            side_bus  [STAGES+1];
    logic             load      [STAGES+1];
    logic             unused_opb;

    // Subtraction is a + ~b + ~cin, so both are inverted on entry.
    assign vld_bus[0]   = in_valid;
    assign carry_bus[0] = cin ^ sub;
    assign word_bus[0]  = a;
    assign opb_bus[0]   = sub ? ~b : b;
    assign side_bus[0]  = {a[WIDTH-1], opb_bus[0][WIDTH-1]};

    // A stage may load when it is empty or when its successor is taking its beat.
    always_comb begin
        load[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            load[k] = !vld_bus[k+1] || load[k+1];
        end
    end

    assign in_ready = load[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_slice #(
            .WIDTH (WIDTH),
            .CW    (CW),
            .IDX   (k)
        ) u_slice (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (load[k]),
            .vld     (vld_bus[k]),
            .carry   (carry_bus[k]),
            .word    (word_bus[k]),
            .opb     (opb_bus[k]),
            .side    (side_bus[k]),
            .vld_p   (vld_bus[k+1]),
            .carry_p (carry_bus[k+1]),
            .word_p  (word_bus[k+1]),
            .opb_p   (opb_bus[k+1]),
            .side_p  (side_bus[k+1])
        );
    end

    // Outputs read as zero whenever no result is held.
    assign out_valid = vld_bus[STAGES];
    assign s         = out_valid ? word_bus[STAGES] : '0;
    assign cout      = out_valid && carry_bus[STAGES];
    assign ovf       = out_valid
                    && (side_bus[STAGES].a_msb == side_bus[STAGES].b_msb)
                    && (word_bus[STAGES][WIDTH-1] != side_bus[STAGES].a_msb);

    assign unused_opb = ^opb_bus[STAGES];

endmodule
